// File: rtl/pose_register_bank.sv
// Six-axis pose accumulator (signed X/Y/Z, modular R1/R2/R3) feeding a frozen
// snapshot to the renderer over a valid/ack handshake.
module pose_register_bank #(
  parameter int POS_W    = 8,
  parameter int POS_STEP = 1,
  parameter int ANG_W    = 9,
  parameter int ANG_MOD  = 360,
  parameter int ANG_STEP = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EnableX,
  input  logic             EnableY,
  input  logic             EnableZ,
  input  logic             add_sub_X,
  input  logic             add_sub_Y,
  input  logic             add_sub_Z,
  input  logic             EnableR1,
  input  logic             EnableR2,
  input  logic             EnableR3,
  input  logic             add_sub_R1,
  input  logic             add_sub_R2,
  input  logic             add_sub_R3,
  input  logic             home,
  input  logic             pose_ack,
  output logic             pose_valid,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [POS_W-1:0] pos_z,
  output logic [ANG_W-1:0] rot_1,
  output logic [ANG_W-1:0] rot_2,
  output logic [ANG_W-1:0] rot_3,
  output logic             sat_flag,
  output logic             state_dbg
);

  // Handshake: pose_valid rises with a fresh snapshot and the snapshot stays
  // frozen until pose_ack is sampled high at a clock edge while pose_valid=1.
  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

  localparam logic signed [POS_W:0] POS_STEP_X = (POS_W+1)'(POS_STEP);
  localparam logic signed [POS_W:0] POS_MAX_X  = (POS_W+1)'(2**(POS_W-1) - 1);
  localparam logic signed [POS_W:0] POS_MIN_X  = (POS_W+1)'(-(2**(POS_W-1)));
  localparam logic [ANG_W:0]        ANG_STEP_X = (ANG_W+1)'(ANG_STEP);
  localparam logic [ANG_W:0]        ANG_MOD_X  = (ANG_W+1)'(ANG_MOD);

  // Returns {clipped, next_value}; the sum is formed one bit wider so overflow is visible.
  function automatic logic [POS_W:0] trans_step(input logic [POS_W-1:0] cur, input logic add);
    logic signed [POS_W:0] ext;
    logic signed [POS_W:0] res;
    ext = $signed({cur[POS_W-1], cur});
    res = add ? ext + POS_STEP_X : ext - POS_STEP_X;
    if (res > POS_MAX_X) return {1'b1, POS_MAX_X[POS_W-1:0]};
    if (res < POS_MIN_X) return {1'b1, POS_MIN_X[POS_W-1:0]};
    return {1'b0, res[POS_W-1:0]};
  endfunction

  function automatic logic [ANG_W-1:0] rot_step(input logic [ANG_W-1:0] cur, input logic add);
    logic [ANG_W:0] t;
    if (add) begin
      t = {1'b0, cur} + ANG_STEP_X;
      if (t >= ANG_MOD_X) t = t - ANG_MOD_X;
    end else if ({1'b0, cur} < ANG_STEP_X) begin
      t = {1'b0, cur} + ANG_MOD_X - ANG_STEP_X;
    end else begin
      t = {1'b0, cur} - ANG_STEP_X;
    end
    return t[ANG_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [POS_W-1:0] lx_q, lx_d, ly_q, ly_d, lz_q, lz_d;
  logic [ANG_W-1:0] lr1_q, lr1_d, lr2_q, lr2_d, lr3_q, lr3_d;
  logic [POS_W-1:0] sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [ANG_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d, sr3_q, sr3_d;
  logic             sat_q, sat_d, dirty_q, dirty_d;
  logic [POS_W-1:0] tx, ty, tz;
  logic             clip_x, clip_y, clip_z, any_upd, capture;

  always_comb begin
    {clip_x, tx} = trans_step(lx_q, add_sub_X);
    {clip_y, ty} = trans_step(ly_q, add_sub_Y);
    {clip_z, tz} = trans_step(lz_q, add_sub_Z);
    any_upd = home | EnableX | EnableY | EnableZ | EnableR1 | EnableR2 | EnableR3;

    lx_d  = EnableX  ? tx : lx_q;
    ly_d  = EnableY  ? ty : ly_q;
    lz_d  = EnableZ  ? tz : lz_q;
    lr1_d = EnableR1 ? rot_step(lr1_q, add_sub_R1) : lr1_q;
    lr2_d = EnableR2 ? rot_step(lr2_q, add_sub_R2) : lr2_q;
    lr3_d = EnableR3 ? rot_step(lr3_q, add_sub_R3) : lr3_q;
    sat_d = sat_q | (EnableX & clip_x) | (EnableY & clip_y) | (EnableZ & clip_z);
    if (home) begin
      lx_d  = '0;
      ly_d  = '0;
      lz_d  = '0;
      lr1_d = '0;
      lr2_d = '0;
      lr3_d = '0;
      sat_d = 1'b0;
    end

    // Snapshot copies the registered live values, never the ones being written now.
    capture = (state_q == S_IDLE) && dirty_q;
    state_d = state_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    sz_d  = sz_q;
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    sr3_d = sr3_q;
    case (state_q)
      S_IDLE: if (dirty_q) begin
        state_d = S_PEND;
        sx_d  = lx_q;
        sy_d  = ly_q;
        sz_d  = lz_q;
        sr1_d = lr1_q;
        sr2_d = lr2_q;
        sr3_d = lr3_q;
      end
      S_PEND: if (pose_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    dirty_d = any_upd ? 1'b1 : (capture ? 1'b0 : dirty_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lx_q  <= '0;
      ly_q  <= '0;
      lz_q  <= '0;
      lr1_q <= '0;
      lr2_q <= '0;
      lr3_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      sz_q  <= '0;
      sr1_q <= '0;
      sr2_q <= '0;
      sr3_q <= '0;
      sat_q   <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lx_q  <= lx_d;
      ly_q  <= ly_d;
      lz_q  <= lz_d;
      lr1_q <= lr1_d;
      lr2_q <= lr2_d;
      lr3_q <= lr3_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      sz_q  <= sz_d;
      sr1_q <= sr1_d;
      sr2_q <= sr2_d;
      sr3_q <= sr3_d;
      sat_q   <= sat_d;
      dirty_q <= dirty_d;
    end
  end

  assign pose_valid = (state_q == S_PEND);
  assign state_dbg  = state_q;
  assign pos_x      = sx_q;
  assign pos_y      = sy_q;
  assign pos_z      = sz_q;
  assign rot_1      = sr1_q;
  assign rot_2      = sr2_q;
  assign rot_3      = sr3_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_pose_register_bank.sv
// Self-checking bench for pose_register_bank: cycle model plus a snapshot
// scoreboard queue popped when the DUT raises pose_valid.
module tb_pose_register_bank;

  logic clock, reset;
  logic EnableX, EnableY, EnableZ, add_sub_X, add_sub_Y, add_sub_Z;
  logic EnableR1, EnableR2, EnableR3, add_sub_R1, add_sub_R2, add_sub_R3;
  logic home, pose_ack;
  logic pose_valid, sat_flag, state_dbg;
  logic [7:0] pos_x, pos_y, pos_z;
  logic [8:0] rot_1, rot_2, rot_3;

  pose_register_bank dut (
    .clock(clock), .reset(reset),
    .EnableX(EnableX), .EnableY(EnableY), .EnableZ(EnableZ),
    .add_sub_X(add_sub_X), .add_sub_Y(add_sub_Y), .add_sub_Z(add_sub_Z),
    .EnableR1(EnableR1), .EnableR2(EnableR2), .EnableR3(EnableR3),
    .add_sub_R1(add_sub_R1), .add_sub_R2(add_sub_R2), .add_sub_R3(add_sub_R3),
    .home(home), .pose_ack(pose_ack), .pose_valid(pose_valid),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .rot_1(rot_1), .rot_2(rot_2), .rot_3(rot_3),
    .sat_flag(sat_flag), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard and model state
  logic [50:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int mx, my, mz, mr1, mr2, mr3;
  logic msat, mdirty, mpend, prev_valid;
  logic [50:0] msnap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [50:0] pack(int x, int y, int z, int r1, int r2, int r3);
    return {8'(x), 8'(y), 8'(z), 9'(r1), 9'(r2), 9'(r3)};
  endfunction

  function automatic int tmove(int cur, logic e, logic a);
    return e ? cur + (a ? 1 : -1) : cur;
  endfunction

  function automatic int clampv(int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic int rmove(int cur, logic e, logic a);
    return e ? (cur + (a ? 5 : 355)) % 360 : cur;
  endfunction

  function automatic logic [50:0] dut_pose();
    return {pos_x, pos_y, pos_z, rot_1, rot_2, rot_3};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mz = 0; mr1 = 0; mr2 = 0; mr3 = 0;
    msat = 1'b0; mdirty = 1'b0; mpend = 1'b0; prev_valid = 1'b0;
    msnap = '0;
    exp_q.delete();
  endtask

  // Driver: en/as ordered {X, Y, Z, R1, R2, R3}
  task automatic cycle(input logic [5:0] en, input logic [5:0] as, input logic hm, input logic ak);
    int nx, ny, nz, nr1, nr2, nr3;
    logic ns, cap, nd, np;
    logic [50:0] nsnap;
    {EnableX, EnableY, EnableZ, EnableR1, EnableR2, EnableR3} = en;
    {add_sub_X, add_sub_Y, add_sub_Z, add_sub_R1, add_sub_R2, add_sub_R3} = as;
    home = hm;
    pose_ack = ak;
    cap = !mpend && mdirty;
    nsnap = cap ? pack(mx, my, mz, mr1, mr2, mr3) : msnap;
    if (cap) exp_q.push_back(nsnap);
    np = mpend ? !ak : mdirty;
    nd = (|en || hm) ? 1'b1 : (cap ? 1'b0 : mdirty);
    nx = tmove(mx, en[5], as[5]);
    ny = tmove(my, en[4], as[4]);
    nz = tmove(mz, en[3], as[3]);
    ns = msat || (nx != clampv(nx)) || (ny != clampv(ny)) || (nz != clampv(nz));
    nx = clampv(nx); ny = clampv(ny); nz = clampv(nz);
    nr1 = rmove(mr1, en[2], as[2]);
    nr2 = rmove(mr2, en[1], as[1]);
    nr3 = rmove(mr3, en[0], as[0]);
    if (hm) begin
      nx = 0; ny = 0; nz = 0; nr1 = 0; nr2 = 0; nr3 = 0; ns = 1'b0;
    end
    @(posedge clock);
    #1;
    mx = nx; my = ny; mz = nz; mr1 = nr1; mr2 = nr2; mr3 = nr3;
    msat = ns; mdirty = nd; mpend = np; msnap = nsnap;
    check("pose_valid", pose_valid, mpend);
    check("state_dbg", state_dbg, mpend);
    check("sat_flag", sat_flag, msat);
    if (pose_valid && !prev_valid && exp_q.size() > 0)
      check("snapshot", dut_pose(), exp_q.pop_front());
    check("snap_hold", dut_pose(), msnap);
    prev_valid = pose_valid;
  endtask

  task automatic idle(input logic ak);
    cycle(6'b0, 6'b0, 1'b0, ak);
  endtask

  // Ack until no snapshot is pending or owed
  task automatic drain();
    for (int i = 0; i < 6; i++)
      if (mpend || mdirty) idle(1'b1);
  endtask

  initial begin
    reset = 1'b1;
    {EnableX, EnableY, EnableZ, EnableR1, EnableR2, EnableR3} = '0;
    {add_sub_X, add_sub_Y, add_sub_Z, add_sub_R1, add_sub_R2, add_sub_R3} = '0;
    home = 1'b0;
    pose_ack = 1'b0;
    model_reset();
    #3;
    check("rst_valid", pose_valid, 1'b0);
    check("rst_pose", dut_pose(), 51'd0);
    check("rst_sat", sat_flag, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single X add: valid one edge after the strobe, then ack
    cycle(6'b100000, 6'b100000, 1'b0, 1'b0);
    check("valid_not_yet", pose_valid, 1'b0);
    idle(1'b0);
    check("x_one_valid", pose_valid, 1'b1);
    check("x_one", dut_pose(), pack(1, 0, 0, 0, 0, 0));
    idle(1'b1);
    check("ack_drops_valid", pose_valid, 1'b0);

    // Drive X into negative saturation, acking every snapshot
    for (int i = 0; i < 130; i++) cycle(6'b100000, 6'b000000, 1'b0, 1'b1);
    drain();
    check("x_sat_val", pos_x, 8'h80);
    check("x_sat_flag", sat_flag, 1'b1);
    cycle(6'b0, 6'b0, 1'b1, 1'b0);
    drain();
    check("home_pose", dut_pose(), 51'd0);
    check("home_sat", sat_flag, 1'b0);

    // Rotation wrap below zero, then 72 adds around the full circle
    cycle(6'b000100, 6'b000000, 1'b0, 1'b0);
    drain();
    check("r1_wrap_down", rot_1, 9'd355);
    cycle(6'b0, 6'b0, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 72; i++) cycle(6'b000100, 6'b000100, 1'b0, 1'b1);
    drain();
    check("r1_full_turn", rot_1, 9'd0);

    // Coalescing while the renderer holds off ack
    cycle(6'b0, 6'b0, 1'b1, 1'b0);
    drain();
    cycle(6'b010000, 6'b010000, 1'b0, 1'b0);
    cycle(6'b010010, 6'b010010, 1'b0, 1'b0);
    cycle(6'b010010, 6'b010010, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("pend_frozen_y", pos_y, 8'd1);
    idle(1'b1);
    check("ack_low_cycle", pose_valid, 1'b0);
    idle(1'b0);
    check("coalesced_y", pos_y, 8'd3);
    check("coalesced_r2", rot_2, 9'd10);
    drain();

    // home beats a same-cycle Z strobe
    cycle(6'b001000, 6'b001000, 1'b0, 1'b1);
    cycle(6'b001000, 6'b001000, 1'b0, 1'b1);
    drain();
    check("z_before_home", pos_z, 8'd2);
    cycle(6'b001000, 6'b001000, 1'b1, 1'b0);
    drain();
    check("home_wins_z", pos_z, 8'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [5:0] en, as;
      en = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
      as = 6'($urandom_range(0, 63));
      cycle(en, as, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end
    drain();

    // Asynchronous reset while a nonzero snapshot is pending
    cycle(6'b101001, 6'b100001, 1'b0, 1'b0);
    idle(1'b0);
    check("pre_reset_valid", pose_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", pose_valid, 1'b0);
    check("async_rst_pose", dut_pose(), 51'd0);
    check("async_rst_sat", sat_flag, 1'b0);
    model_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("no_snap_after_rst", pose_valid, 1'b0);
    cycle(6'b000001, 6'b000000, 1'b0, 1'b0);
    idle(1'b0);
    check("post_rst_r3", rot_3, 9'd355);
    drain();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
